// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Registered ALU-control sequencer for the multicycle processor. Takes one
//   operation request per valid/ready handshake and drives the ALU, the shifter,
//   the ALUOut source mux and the control-unit branch-compare signals. Shift
//   operations run as a LOAD pass followed by a counted run of SHIFT passes.
//   Completion is flagged by a one-cycle `done` pulse.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   op_valid/op_code/op_steps  request (op_steps = extra shift passes)
//   op_ready                   high only while idle
//   alu_zero/alu_lt/alu_gt     ALU compare flags (branch evaluation)
//   ALU_control, SHIFTER_control, M_SHIFTER, M_ALUOut_control   datapath controls
//   UC_control, UC_op          branch-compare active / branch kind
//   branch_taken               registered branch result, held until next accept
//   done, illegal_op           completion pulse / illegal-code pulse
//
// Build option
//   ALUSEQ_BRANCH_EVAL_EN : when defined, branches are evaluated here and
//   branch_taken is driven; otherwise branch_taken is tied to 0.
module alu_op_sequencer #(
  parameter int OP_W         = 4,
  parameter int ALU_CTRL_W   = 3,
  parameter int SHIFT_CTRL_W = 3,
  parameter int STEP_W       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic [OP_W-1:0]         op_code,
  input  logic [STEP_W-1:0]       op_steps,
  output logic                    op_ready,
  input  logic                    alu_zero,
  input  logic                    alu_lt,
  input  logic                    alu_gt,
  output logic [ALU_CTRL_W-1:0]   ALU_control,
  output logic [SHIFT_CTRL_W-1:0] SHIFTER_control,
  output logic                    M_SHIFTER,
  output logic [1:0]              M_ALUOut_control,
  output logic                    UC_control,
  output logic [1:0]              UC_op,
  output logic                    branch_taken,
  output logic                    done,
  output logic                    illegal_op
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  localparam logic [3:0] C_ADD  = 4'd1;
  localparam logic [3:0] C_SUB  = 4'd2;
  localparam logic [3:0] C_AND  = 4'd3;
  localparam logic [3:0] C_PASS = 4'd4;
  localparam logic [3:0] C_SHL1 = 4'd5;
  localparam logic [3:0] C_SHL2 = 4'd6;
  localparam logic [3:0] C_SHR  = 4'd7;
  localparam logic [3:0] C_SRA1 = 4'd8;
  localparam logic [3:0] C_SRA2 = 4'd9;
  localparam logic [3:0] C_SLTI = 4'd10;
  localparam logic [3:0] C_BEQ  = 4'd11;
  localparam logic [3:0] C_BNE  = 4'd12;
  localparam logic [3:0] C_BLE  = 4'd13;
  localparam logic [3:0] C_BGT  = 4'd14;
  localparam logic [3:0] C_LUI  = 4'd15;

  function automatic logic is_shift(input logic [3:0] c);
    return (c >= C_SHL1 && c <= C_SRA2) || (c == C_LUI);
  endfunction

  function automatic logic is_branch(input logic [3:0] c);
    return (c >= C_BEQ && c <= C_BGT);
  endfunction

  function automatic logic [1:0] branch_kind(input logic [3:0] c);
    logic [3:0] d;
    d = c - C_BEQ;
    return d[1:0];
  endfunction

  // Number of SHIFT passes; one extra counter bit so the all-ones step field
  // yields 2^STEP_W passes without wrapping.
  function automatic logic [STEP_W:0] pass_count(input logic [3:0] c,
                                                 input logic [STEP_W-1:0] s);
    logic [STEP_W:0] n;
    case (c)
      C_SHL2, C_SRA2: n = (STEP_W+1)'(2);
      C_LUI:          n = (STEP_W+1)'(1);
      default:        n = {1'b0, s} + (STEP_W+1)'(1);
    endcase
    return n;
  endfunction

  function automatic logic [SHIFT_CTRL_W-1:0] shift_kind(input logic [3:0] c);
    logic [SHIFT_CTRL_W-1:0] k;
    case (c)
      C_SHR:          k = SHIFT_CTRL_W'(3'b011);
      C_SRA1, C_SRA2: k = SHIFT_CTRL_W'(3'b100);
      default:        k = SHIFT_CTRL_W'(3'b010);
    endcase
    return k;
  endfunction

  // Illegal codes are folded into NO_OP at capture; only the flag survives.
  logic       in_illegal;
  logic [3:0] in_code;
  assign in_illegal = ((op_code >> 4) != '0);
  assign in_code    = in_illegal ? 4'd0 : op_code[3:0];

  logic [1:0]        state_reg, state_next;
  logic [3:0]        code_reg, code_next;
  logic              illegal_reg, illegal_next;
  logic [STEP_W:0]   cnt_reg, cnt_next;
  logic              done_next;

  always_comb begin
    state_next   = state_reg;
    code_next    = code_reg;
    illegal_next = illegal_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: if (op_valid) begin
        code_next    = in_code;
        illegal_next = in_illegal;
        cnt_next     = pass_count(in_code, op_steps);
        state_next   = is_shift(in_code) ? LOAD : EXEC;
      end
      EXEC: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      LOAD: state_next = SHIFT;
      default: begin
        if (cnt_reg == (STEP_W+1)'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - (STEP_W+1)'(1);
        end
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // and line up with the state they describe.
  logic [ALU_CTRL_W-1:0]   alu_next;
  logic [SHIFT_CTRL_W-1:0] shifter_next;
  logic                    m_shifter_next;
  logic [1:0]              m_aluout_next;
  logic                    uc_control_next;
  logic [1:0]              uc_op_next;

  always_comb begin
    alu_next        = '0;
    shifter_next    = '0;
    m_shifter_next  = 1'b0;
    m_aluout_next   = 2'b00;
    uc_control_next = 1'b0;
    uc_op_next      = 2'b00;
    case (state_next)
      EXEC: begin
        case (code_next)
          C_ADD: begin alu_next = ALU_CTRL_W'(3'b001); m_aluout_next = 2'b01; end
          C_SUB: begin alu_next = ALU_CTRL_W'(3'b010); m_aluout_next = 2'b01; end
          C_AND: begin alu_next = ALU_CTRL_W'(3'b011); m_aluout_next = 2'b01; end
          C_PASS: m_aluout_next = 2'b10;
          C_SLTI, C_BEQ, C_BNE, C_BLE, C_BGT: begin
            alu_next      = ALU_CTRL_W'(3'b111);
            m_aluout_next = 2'b11;
          end
          default: m_aluout_next = 2'b01;
        endcase
        if (is_branch(code_next)) begin
          uc_control_next = 1'b1;
          uc_op_next      = branch_kind(code_next);
        end
      end
      LOAD: begin
        shifter_next   = SHIFT_CTRL_W'(3'b001);
        m_aluout_next  = 2'b10;
        m_shifter_next = (code_next == C_LUI);
      end
      SHIFT: begin
        shifter_next   = shift_kind(code_next);
        m_aluout_next  = 2'b10;
        m_shifter_next = (code_next == C_LUI);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      code_reg         <= 4'd0;
      illegal_reg      <= 1'b0;
      cnt_reg          <= '0;
      op_ready         <= 1'b1;
      ALU_control      <= '0;
      SHIFTER_control  <= '0;
      M_SHIFTER        <= 1'b0;
      M_ALUOut_control <= 2'b00;
      UC_control       <= 1'b0;
      UC_op            <= 2'b00;
      done             <= 1'b0;
      illegal_op       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      code_reg         <= code_next;
      illegal_reg      <= illegal_next;
      cnt_reg          <= cnt_next;
      op_ready         <= (state_next == IDLE);
      ALU_control      <= alu_next;
      SHIFTER_control  <= shifter_next;
      M_SHIFTER        <= m_shifter_next;
      M_ALUOut_control <= m_aluout_next;
      UC_control       <= uc_control_next;
      UC_op            <= uc_op_next;
      done             <= done_next;
      illegal_op       <= done_next & illegal_reg;
    end
  end

`ifdef ALUSEQ_BRANCH_EVAL_EN
  logic cond;
  always_comb begin
    case (code_reg)
      C_BEQ:   cond = alu_zero;
      C_BNE:   cond = !alu_zero;
      C_BLE:   cond = alu_lt | alu_zero;
      default: cond = alu_gt;
    endcase
  end

  // Cleared on acceptance, loaded when EXEC of a branch completes, then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_taken <= 1'b0;
    end else if (state_reg == IDLE && op_valid) begin
      branch_taken <= 1'b0;
    end else if (state_reg == EXEC && is_branch(code_reg)) begin
      branch_taken <= cond;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = alu_zero ^ alu_lt ^ alu_gt;
  assign branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       op_valid = 1'b0;
  logic [4:0] op_code = 5'd0;
  logic [1:0] op_steps = 2'd0;
  logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_gt = 1'b0;
  logic       op_ready;
  logic [2:0] ALU_control;
  logic [2:0] SHIFTER_control;
  logic       M_SHIFTER;
  logic [1:0] M_ALUOut_control;
  logic       UC_control;
  logic [1:0] UC_op;
  logic       branch_taken, done, illegal_op;

  alu_op_sequencer #(.OP_W(5), .ALU_CTRL_W(3), .SHIFT_CTRL_W(3), .STEP_W(2)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_steps(op_steps), .op_ready(op_ready), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .alu_gt(alu_gt), .ALU_control(ALU_control),
    .SHIFTER_control(SHIFTER_control), .M_SHIFTER(M_SHIFTER),
    .M_ALUOut_control(M_ALUOut_control), .UC_control(UC_control),
    .UC_op(UC_op), .branch_taken(branch_taken), .done(done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {ready, done, illegal, taken, uc_ctl, uc_op[2], aluout[2], m_shifter, shifter[3], alu[3]}
  logic [15:0] obs;
  assign obs = {op_ready, done, illegal_op, branch_taken, UC_control, UC_op,
                M_ALUOut_control, M_SHIFTER, SHIFTER_control, ALU_control};

  int pass_count = 0;
  int check_count = 0;
  int n_txn = 0;
  bit bt_model = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [15:0] pack(input bit rdy, input bit dn, input bit ill, input bit bt,
                                       input bit ucc, input logic [1:0] ucop, input logic [1:0] mout,
                                       input bit msh, input logic [2:0] sh, input logic [2:0] alu);
    return {rdy, dn, ill, bt, ucc, ucop, mout, msh, sh, alu};
  endfunction

  function automatic logic [15:0] idle_exp();
    return pack(1'b1, 1'b0, 1'b0, bt_model, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0);
  endfunction

  // Reference model: the per-cycle output trace of one operation, from the
  // cycle after acceptance through the done cycle.
  task automatic build_expect(input int code, input int steps, input bit z, input bit lt, input bit gt);
    int c, n;
    bit ill, lui, br, taken;
    logic [2:0] sh, alu;
    logic [1:0] mout, ucop;
    exp_q.delete();
    ill = (code >= 16);
    c = ill ? 0 : code;
    if (c inside {5, 6, 7, 8, 9, 15}) begin
      if (c == 6 || c == 9) n = 2;
      else if (c == 15) n = 1;
      else n = steps + 1;
      sh  = (c == 7) ? 3'd3 : ((c == 8 || c == 9) ? 3'd4 : 3'd2);
      lui = (c == 15);
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, lui, 3'd1, 3'd0));
      for (int k = 0; k < n; k++)
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, lui, sh, 3'd0));
      bt_model = 1'b0;
      exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0));
    end else begin
      alu  = (c == 1) ? 3'd1 : (c == 2) ? 3'd2 : (c == 3) ? 3'd3 : (c >= 10) ? 3'd7 : 3'd0;
      mout = (c == 4) ? 2'd2 : (c >= 10) ? 2'd3 : 2'd1;
      br   = (c >= 11);
      ucop = br ? 2'(c - 11) : 2'd0;
      case (c)
        11:      taken = z;
        12:      taken = !z;
        13:      taken = lt | z;
        14:      taken = gt;
        default: taken = 1'b0;
      endcase
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, br, ucop, mout, 1'b0, 3'd0, alu));
`ifdef ALUSEQ_BRANCH_EVAL_EN
      bt_model = br && taken;
`else
      bt_model = 1'b0;
`endif
      exp_q.push_back(pack(1'b1, 1'b1, ill, bt_model, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0));
    end
  endtask

  // Entered and left at a negedge of an idle cycle. abort_at > 0 asserts
  // reset after checking that cycle of the operation.
  task automatic run_op(input int code, input int steps, input bit z, input bit lt, input bit gt,
                        input int gap, input int abort_at);
    int len;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_value("idle", obs, idle_exp());
    end
    build_expect(code, steps, z, lt, gt);
    len = exp_q.size();
    n_txn++;
    $display("txn %0d: code=%0d steps=%0d flags(z,lt,gt)=%0d%0d%0d cycles=%0d",
             n_txn, code, steps, z, lt, gt, len);
    op_valid = 1'b1;
    op_code  = 5'(code);
    op_steps = 2'(steps);
    alu_zero = z; alu_lt = lt; alu_gt = gt;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check_value($sformatf("txn%0d_cyc%0d", n_txn, k), obs, exp_q[k-1]);
      if (k == abort_at) begin
        op_valid = 1'b0;
        #1 reset = 1'b1;
        bt_model = 1'b0;
        #1 check_value("reset_mid", obs, idle_exp());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < len; j++) begin
          @(negedge clk);
          check_value("after_abort", obs, idle_exp());
        end
        return;
      end
      if (k < len) begin
        // Noise on the request while busy must be ignored.
        op_valid = 1'($urandom);
        op_code  = 5'($urandom);
        op_steps = 2'($urandom);
      end else begin
        op_valid = 1'b0;
      end
    end
  endtask

  int d_code[7]  = '{1, 7, 13, 12, 15, 1, 20};
  int d_steps[7] = '{0, 3, 0, 0, 0, 0, 0};
  bit d_z[7]     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int d_gap[7]   = '{1, 1, 1, 1, 1, 0, 1};

  initial begin
    #2 reset = 1'b1;
    @(negedge clk);
    check_value("reset_state", obs, idle_exp());
    reset = 1'b0;
    @(negedge clk);
    check_value("idle_after_reset", obs, idle_exp());

    for (int i = 0; i < 7; i++)
      run_op(d_code[i], d_steps[i], d_z[i], 1'b0, 1'b0, d_gap[i], 0);

    // SHR with 4 passes, reset asserted during its second SHIFT cycle.
    run_op(7, 3, 1'b0, 1'b0, 1'b0, 1, 3);

    for (int i = 0; i < 60; i++)
      run_op(int'($urandom_range(0, 23)), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0);

    @(negedge clk);
    check_value("final_idle", obs, idle_exp());
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised, registered successor to the multicycle ALU-control decoder. Accepts an ALU operation request via a valid/ready handshake and drives ALU, shifter, ALUOut-mux and control-unit signals. Multi-cycle operations (load-then-shift with a configurable pass count) are sequenced by an internal FSM, and completion is signalled by a `done` pulse. Sits between the main control-unit FSM and the datapath ALU/shifter of the multicycle processor.

## Interface
- `OP_W`, 4: opcode width (≥4); codes ≥16 are illegal.
- `ALU_CTRL_W`, 3: ALU control width.
- `SHIFT_CTRL_W`, 3: shifter control width.
- `STEP_W`, 2: width of shift pass-count field.
---
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  request valid.
- `op_code`  in  OP_W  operation code.
- `op_steps`  in  STEP_W  extra shift passes (N = op_steps+1).
- `op_ready`  out  1  high only in IDLE.
- `alu_zero`, `alu_lt`, `alu_gt`  in  1 each  ALU compare flags.
- `ALU_control`  out  ALU_CTRL_W.
- `SHIFTER_control`  out  SHIFT_CTRL_W.
- `M_SHIFTER`  out  1  shift-amount mux select (1 = constant 16).
- `M_ALUOut_control`  out  2  ALUOut source select.
- `UC_control`  out  1  branch-compare active.
- `UC_op`  out  2  branch kind (00 BEQ, 01 BNE, 10 BLE, 11 BGT).
- `branch_taken`  out  1  registered branch result.
- `done`  out  1  one-cycle completion pulse.
- `illegal_op`  out  1  one-cycle pulse alongside `done` for illegal code.

## Operation
- Codes: 0 NO_OP, 1 ADD, 2 SUB, 3 AND, 4 PASS_B, 5 SHL1, 6 SHL2, 7 SHR, 8 SRA1, 9 SRA2, 10 SLTI, 11 BEQ, 12 BNE, 13 BLE, 14 BGT, 15 LUI.
- FSM states: IDLE, EXEC, LOAD, SHIFT. Accept on `op_valid && op_ready`; code and steps are captured. `op_valid` is ignored outside IDLE, so the requester holds its request.
- Single-cycle ops (0–4, 10–14, illegal): IDLE→EXEC→IDLE.
  - ALU_control: ADD 001, SUB 010, AND 011, compares 111, others 000.
  - M_ALUOut_control: NO_OP/ADD/SUB/AND 01, PASS_B 10, compares 11.
  - Illegal codes behave as NO_OP.
- Branches (11–14): in EXEC, UC_control=1 and UC_op per table. Condition: BEQ `alu_zero`; BNE `!alu_zero`; BLE `alu_lt|alu_zero`; BGT `alu_gt`.
- Shift ops (5–9, 15): IDLE→LOAD (1 cycle, SHIFTER_control=001)→SHIFT (N cycles)→IDLE.
  - SHIFTER_control in SHIFT: SHL 010, SHR 011, SRA 100.
  - N = op_steps+1 for SHL1/SHR/SRA1; N = 2 fixed for SHL2/SRA2; N = 1 for LUI.
  - M_ALUOut_control=10 in LOAD and SHIFT. M_SHIFTER=1 only for LUI, in both LOAD and SHIFT.
- Pass counter: STEP_W+1 bits, counts down, and never wraps. op_steps=0 gives one pass; the all-ones value gives 2^STEP_W passes.
- In IDLE, all control outputs are 0 so the datapath is not disturbed.

## Timing
- All outputs are registered. Reset value of every output is 0, except `op_ready`=1.
- An op accepted at edge E occupies its active cycles from E+1.
  - Single-cycle op: EXEC is cycle E+1; `done` is high in cycle E+2, together with `op_ready`=1.
  - Shift op: total latency to `done` is N+2 cycles.
- A new op may be accepted in the `done` cycle, giving back-to-back throughput of one single-cycle op per 2 cycles.
- `branch_taken` is sampled at the end of EXEC. It is valid from the `done` cycle and held until the next acceptance, where it clears to 0.
- `illegal_op` coincides with `done`.
- Reset asserted mid-operation forces IDLE and zero outputs immediately (asynchronous). No `done` is issued for the aborted op.

## Configuration
- `ALUSEQ_BRANCH_EVAL_EN`:
  - Defined: the condition is evaluated internally and `branch_taken` is driven as above.
  - Undefined: `branch_taken` is tied to 0 and the flag inputs are unused. The control unit evaluates branches itself from UC_control/UC_op, which behave identically in both builds.

## Test plan
- Reset: assert `reset` mid-SHIFT → outputs 0 and `op_ready`=1 in the same cycle; no `done`.
- ADD (code 1) accepted at E → ALU_control=001 and M_ALUOut_control=01 in E+1; `done` in E+2; all controls 0 in E+2.
- SHR with op_steps=3 → LOAD 1 cycle (001), then SHIFT 4 cycles (011); `done` 6 cycles after acceptance.
- Branches with macro defined:
  - BLE with alu_lt=0, alu_zero=1 → `branch_taken`=1 in the `done` cycle; UC_op=10 in EXEC.
  - BNE with alu_zero=1 → `branch_taken`=0.
- LUI → M_SHIFTER=1 for 2 cycles; SHIFTER_control 001 then 010; `done` at E+3. Back-to-back ADD accepted in the `done` cycle → executes at E+4.
- OP_W=5, code 20 → behaves as NO_OP; `illegal_op` and `done` both high at E+2. `op_valid` pulsed during a busy cycle → ignored, no extra `done`.
